// File: rtl/audio_i2s_slave_rx.sv
// I2S slave receiver: captures left/right word pairs from an external codec master
// and presents them on a valid/ready handshake, with sticky overrun/frame-error flags.
module audio_i2s_slave_rx #(
    parameter int unsigned WORD_W      = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iEN,
    input  logic              AUD_BCLK,
    input  logic              AUD_LRCK,
    input  logic              AUD_ADCDAT,
    output logic [WORD_W-1:0] oDATA_L,
    output logic [WORD_W-1:0] oDATA_R,
    output logic              oVALID,
    input  logic              iREADY,
    output logic              oOVERRUN,
    output logic              oFRAME_ERR,
    input  logic              iCLR_ERR
);

    localparam int unsigned CNT_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] lrck_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   bclk_prev;
    logic                   lrck_prev;
    logic                   ch_right;
    logic                   left_ok;
    logic [CNT_W-1:0]       bit_cnt;
    logic [WORD_W-1:0]      shreg;
    logic [WORD_W-1:0]      left_word;

    logic                   bclk_s;
    logic                   lrck_s;
    logic                   dat_s;
    logic                   bclk_rise;
    logic                   lr_change;
    logic                   last_bit;
    logic [WORD_W-1:0]      shift_next;

    assign bclk_s     = bclk_sync[SYNC_STAGES-1];
    assign lrck_s     = lrck_sync[SYNC_STAGES-1];
    assign dat_s      = dat_sync[SYNC_STAGES-1];
    assign bclk_rise  = bclk_s & ~bclk_prev;
    assign lr_change  = bclk_rise & (lrck_s != lrck_prev);
    assign last_bit   = (bit_cnt == CNT_W'(WORD_W - 1));
    assign shift_next = {shreg[WORD_W-2:0], dat_s};

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state      <= IDLE;
            bclk_sync  <= '0;
            lrck_sync  <= '0;
            dat_sync   <= '0;
            bclk_prev  <= 1'b0;
            lrck_prev  <= 1'b0;
            ch_right   <= 1'b0;
            left_ok    <= 1'b0;
            bit_cnt    <= '0;
            shreg      <= '0;
            left_word  <= '0;
            oDATA_L    <= '0;
            oDATA_R    <= '0;
            oVALID     <= 1'b0;
            oOVERRUN   <= 1'b0;
            oFRAME_ERR <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], AUD_BCLK};
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], AUD_LRCK};
            dat_sync  <= {dat_sync[SYNC_STAGES-2:0], AUD_ADCDAT};
            bclk_prev <= bclk_s;
            if (bclk_rise) begin
                lrck_prev <= lrck_s;
            end

            // Handshake and flag clears come first so that loads and sets below win.
            if (oVALID && iREADY) begin
                oVALID <= 1'b0;
            end
            if (iCLR_ERR) begin
                oOVERRUN   <= 1'b0;
                oFRAME_ERR <= 1'b0;
            end

            if (!iEN) begin
                state   <= IDLE;
                left_ok <= 1'b0;
            end else if (bclk_rise) begin
                case (state)
                    IDLE: begin
                        if (lr_change && !lrck_s) begin
                            state    <= SHIFT;
                            ch_right <= 1'b0;
                            bit_cnt  <= '0;
                            left_ok  <= 1'b0;
                        end
                    end
                    SHIFT: begin
                        if (lr_change) begin
                            // Channel switched before the word filled: drop it and restart.
                            oFRAME_ERR <= 1'b1;
                            left_ok    <= 1'b0;
                            ch_right   <= lrck_s;
                            bit_cnt    <= '0;
                        end else begin
                            shreg   <= shift_next;
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            if (last_bit) begin
                                state <= HOLD;
                                if (!ch_right) begin
                                    left_word <= shift_next;
                                    left_ok   <= 1'b1;
                                end else if (left_ok) begin
                                    if (!oVALID || iREADY) begin
                                        oDATA_L <= left_word;
                                        oDATA_R <= shift_next;
                                        oVALID  <= 1'b1;
                                    end else begin
                                        oOVERRUN <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    HOLD: begin
                        if (lr_change) begin
                            state    <= SHIFT;
                            ch_right <= lrck_s;
                            bit_cnt  <= '0;
                            if (!lrck_s) begin
                                left_ok <= 1'b0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_audio_i2s_slave_rx.sv
// Directed bench for audio_i2s_slave_rx: drives I2S frames at BCLK = iCLK/16
// and checks captured pairs and flags against hand-computed values.
module tb_audio_i2s_slave_rx;

    logic        iCLK = 1'b0;
    logic        iRST_N = 1'b0;
    logic        iEN = 1'b0;
    logic        AUD_BCLK = 1'b0;
    logic        AUD_LRCK = 1'b0;
    logic        AUD_ADCDAT = 1'b0;
    logic [15:0] oDATA_L;
    logic [15:0] oDATA_R;
    logic        oVALID;
    logic        iREADY = 1'b0;
    logic        oOVERRUN;
    logic        oFRAME_ERR;
    logic        iCLR_ERR = 1'b0;

    int compared = 0;
    int mismatched = 0;

    int          rise_cnt = 0;
    int          xfer_cnt = 0;
    int          run = 0;
    int          max_run = 0;
    logic        valid_d = 1'b0;
    logic [15:0] xfer_l = '0;
    logic [15:0] xfer_r = '0;
    int          base;

    audio_i2s_slave_rx #(.WORD_W(16), .SYNC_STAGES(2)) dut (
        .iCLK       (iCLK),
        .iRST_N     (iRST_N),
        .iEN        (iEN),
        .AUD_BCLK   (AUD_BCLK),
        .AUD_LRCK   (AUD_LRCK),
        .AUD_ADCDAT (AUD_ADCDAT),
        .oDATA_L    (oDATA_L),
        .oDATA_R    (oDATA_R),
        .oVALID     (oVALID),
        .iREADY     (iREADY),
        .oOVERRUN   (oOVERRUN),
        .oFRAME_ERR (oFRAME_ERR),
        .iCLR_ERR   (iCLR_ERR)
    );

    always #5 iCLK = ~iCLK;

    // Handshake monitor, sampled mid-cycle.
    always @(negedge iCLK) begin
        if (oVALID === 1'b1 && valid_d !== 1'b1) rise_cnt++;
        if (oVALID === 1'b1 && iREADY === 1'b1) begin
            xfer_cnt++;
            xfer_l = oDATA_L;
            xfer_r = oDATA_R;
        end
        if (oVALID === 1'b1) begin
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        valid_d = oVALID;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic lr, input logic d);
        @(posedge iCLK); #1;
        AUD_LRCK   = lr;
        AUD_ADCDAT = d;
        AUD_BCLK   = 1'b0;
        repeat (8) @(posedge iCLK);
        #1 AUD_BCLK = 1'b1;
        repeat (7) @(posedge iCLK);
    endtask

    task automatic send_bits(input logic lr, input logic [15:0] word, input int first, input int count);
        for (int i = first; i < first + count; i++) drive_bit(lr, word[15-i]);
    endtask

    // One LRCK period: delay-slot bit, ndata bits MSB first, then extra padding 1s.
    task automatic send_slot(input logic lr, input logic [15:0] word, input int ndata, input int extra);
        drive_bit(lr, 1'b1);
        send_bits(lr, word, 0, ndata);
        for (int i = 0; i < extra; i++) drive_bit(lr, 1'b1);
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int extra);
        send_slot(1'b0, l, 16, extra);
        send_slot(1'b1, r, 16, extra);
    endtask

    task automatic cycle_set(input logic rst_n, input logic en, input logic rdy, input logic clr);
        @(posedge iCLK); #1;
        iRST_N = rst_n; iEN = en; iREADY = rdy; iCLR_ERR = clr;
    endtask

    initial begin
        // Reset state
        repeat (4) @(posedge iCLK);
        @(negedge iCLK);
        check("rst_data_l", 32'(oDATA_L), 32'h0);
        check("rst_data_r", 32'(oDATA_R), 32'h0);
        check("rst_valid", 32'(oVALID), 32'h0);
        check("rst_overrun", 32'(oOVERRUN), 32'h0);
        check("rst_frame_err", 32'(oFRAME_ERR), 32'h0);

        // Basic 16-bit-slot frame, consumer always ready
        cycle_set(1'b1, 1'b1, 1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        base = rise_cnt;
        send_frame(16'hA5C3, 16'h1234, 0);
        @(negedge iCLK);
        check("t1_valid_pulses", 32'(rise_cnt - base), 32'd1);
        check("t1_pulse_width", 32'(max_run), 32'd1);
        check("t1_xfer_l", 32'(xfer_l), 32'hA5C3);
        check("t1_xfer_r", 32'(xfer_r), 32'h1234);
        check("t1_data_l", 32'(oDATA_L), 32'hA5C3);
        check("t1_data_r", 32'(oDATA_R), 32'h1234);
        check("t1_overrun", 32'(oOVERRUN), 32'h0);
        check("t1_frame_err", 32'(oFRAME_ERR), 32'h0);

        // 32-bit slots with trailing padding
        base = rise_cnt;
        send_frame(16'h8001, 16'h7FFE, 16);
        @(negedge iCLK);
        check("t2_valid_pulses", 32'(rise_cnt - base), 32'd1);
        check("t2_xfer_l", 32'(xfer_l), 32'h8001);
        check("t2_xfer_r", 32'(xfer_r), 32'h7FFE);
        check("t2_frame_err", 32'(oFRAME_ERR), 32'h0);

        // Backpressure over two frames: first pair held, second dropped
        cycle_set(1'b1, 1'b1, 1'b0, 1'b0);
        base = xfer_cnt;
        send_frame(16'h1111, 16'h2222, 0);
        send_frame(16'h3333, 16'h4444, 0);
        @(negedge iCLK);
        check("t3_valid_held", 32'(oVALID), 32'h1);
        check("t3_data_l", 32'(oDATA_L), 32'h1111);
        check("t3_data_r", 32'(oDATA_R), 32'h2222);
        check("t3_overrun", 32'(oOVERRUN), 32'h1);
        cycle_set(1'b1, 1'b1, 1'b1, 1'b0);
        cycle_set(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge iCLK);
        check("t3_valid_fell", 32'(oVALID), 32'h0);
        check("t3_one_xfer", 32'(xfer_cnt - base), 32'd1);
        check("t3_xfer_l", 32'(xfer_l), 32'h1111);
        check("t3_overrun_sticky", 32'(oOVERRUN), 32'h1);
        cycle_set(1'b1, 1'b1, 1'b1, 1'b1);
        cycle_set(1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge iCLK);
        check("t3_overrun_clr", 32'(oOVERRUN), 32'h0);

        // LRCK toggles after 10 left bits
        base = rise_cnt;
        send_slot(1'b0, 16'h5A5A, 10, 0);
        send_slot(1'b1, 16'h9876, 16, 0);
        @(negedge iCLK);
        check("t4_frame_err", 32'(oFRAME_ERR), 32'h1);
        check("t4_no_valid", 32'(rise_cnt - base), 32'd0);
        send_frame(16'hCAFE, 16'hBEEF, 0);
        @(negedge iCLK);
        check("t4_good_pulses", 32'(rise_cnt - base), 32'd1);
        check("t4_xfer_l", 32'(xfer_l), 32'hCAFE);
        check("t4_xfer_r", 32'(xfer_r), 32'hBEEF);
        check("t4_err_sticky", 32'(oFRAME_ERR), 32'h1);
        cycle_set(1'b1, 1'b1, 1'b1, 1'b1);
        cycle_set(1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge iCLK);
        check("t4_err_clr", 32'(oFRAME_ERR), 32'h0);

        // Reset pulse in the middle of a right word
        send_slot(1'b0, 16'hAAAA, 16, 0);
        drive_bit(1'b1, 1'b1);
        send_bits(1'b1, 16'h5555, 0, 8);
        @(posedge iCLK); #1 AUD_BCLK = 1'b0;
        repeat (8) @(posedge iCLK);
        cycle_set(1'b0, 1'b1, 1'b1, 1'b0);
        cycle_set(1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge iCLK);
        check("t5_data_l", 32'(oDATA_L), 32'h0);
        check("t5_data_r", 32'(oDATA_R), 32'h0);
        check("t5_valid", 32'(oVALID), 32'h0);
        check("t5_flags", 32'({oOVERRUN, oFRAME_ERR}), 32'h0);
        base = rise_cnt;
        send_bits(1'b1, 16'h5555, 8, 8);
        @(negedge iCLK);
        check("t5_no_valid_tail", 32'(rise_cnt - base), 32'd0);
        send_slot(1'b0, 16'h0F0F, 16, 0);
        @(negedge iCLK);
        check("t5_no_valid_left", 32'(rise_cnt - base), 32'd0);
        send_slot(1'b1, 16'hF0F0, 16, 0);
        @(negedge iCLK);
        check("t5_valid_after", 32'(rise_cnt - base), 32'd1);
        check("t5_xfer_l", 32'(xfer_l), 32'h0F0F);
        check("t5_xfer_r", 32'(xfer_r), 32'hF0F0);

        // Disabled through a frame start, enabled mid-left word
        cycle_set(1'b1, 1'b0, 1'b1, 1'b0);
        base = rise_cnt;
        drive_bit(1'b0, 1'b1);
        send_bits(1'b0, 16'h9999, 0, 5);
        cycle_set(1'b1, 1'b1, 1'b1, 1'b0);
        send_bits(1'b0, 16'h9999, 5, 11);
        send_slot(1'b1, 16'h6666, 16, 0);
        @(negedge iCLK);
        check("t6_no_valid", 32'(rise_cnt - base), 32'd0);
        send_frame(16'h1357, 16'h2468, 0);
        @(negedge iCLK);
        check("t6_next_valid", 32'(rise_cnt - base), 32'd1);
        check("t6_xfer_l", 32'(xfer_l), 32'h1357);
        check("t6_xfer_r", 32'(xfer_r), 32'h2468);
        check("t6_flags", 32'({oOVERRUN, oFRAME_ERR}), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
